hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Pipeline interlock controller for the 5-stage MIPS core. Watches the ID stage's decoded
//   fields (rs/rt, muldiv/HI-LO use, branch outcome), the EX stage and the memory ports.
//   Drives stall, bubble and flush controls for PC, IF/ID and ID/EX. Sequences the
//   multi-cycle MULT/DIV unit (start pulse, busy tracking, HI/LO interlock).
// PARAMETERS
//   MULT_CYCLES  4   cycles from muldiv_start to HI/LO valid for MULT/MULTU (>=1)
//   DIV_CYCLES   32  cycles from muldiv_start to HI/LO valid for DIV/DIVU (>=1)
//   BRANCH_FLUSH 0   0: delay-slot ISA, taken branch never flushes IF/ID; 1: taken branch flushes IF/ID
//   CNT_W        32  width of performance counters (PERF option only)
// PORTS
//   clk            in   1   core clock, rising edge
//   rst            in   1   asynchronous reset, active-low (0 = reset)
//   id_rs, id_rt   in   5   source register numbers of the instruction in ID
//   id_use_rs/rt   in   1   ID instruction actually reads rs / rt
//   id_muldiv_op   in   2   00 none, 01 MULT/MULTU, 10 DIV/DIVU, 11 reserved (treated as none)
//   id_reads_hilo  in   1   ID instruction is MFHI/MFLO
//   id_branch_taken in  1   branch/jump in ID resolved taken this cycle
//   ex_mem_read    in   1   instruction in EX is a load
//   ex_wd          in   5   destination register of instruction in EX
//   imem_busy      in   1   instruction memory not ready this cycle
//   dmem_busy      in   1   data memory not ready this cycle
//   stall_pc       out  1   hold PC
//   stall_if_id    out  1   hold IF/ID register
//   stall_id_ex    out  1   hold ID/EX (and later stages)
//   bubble_id_ex   out  1   load NOP into ID/EX
//   flush_if_id    out  1   load NOP into IF/ID
//   muldiv_start   out  1   one-cycle start pulse to MULT/DIV unit
//   muldiv_busy    out  1   MULT/DIV unit in progress
// BEHAVIOUR
//   - Control outputs combinational from state + inputs; state/counters registered.
//   - Reset (rst=0, async): state IDLE, count 0, perf counters 0; outputs then follow inputs.
//   - Priority, highest first, one action per cycle:
//     1 MEM_WAIT: imem_busy|dmem_busy -> stall_pc=stall_if_id=stall_id_ex=1; no bubble/flush/start.
//     2 LOAD_USE: ex_mem_read & ex_wd!=0 & ((id_use_rs & id_rs==ex_wd)|(id_use_rt & id_rt==ex_wd))
//       -> stall_pc=stall_if_id=1, bubble_id_ex=1; branch in ID ignored this cycle.
//     3 HILO: muldiv_busy & (id_muldiv_op in {01,10} | id_reads_hilo) -> stall_pc=stall_if_id=1, bubble_id_ex=1.
//     4 START: state IDLE & id_muldiv_op in {01,10} -> muldiv_start=1 for exactly one cycle.
//     5 BRANCH: id_branch_taken & BRANCH_FLUSH -> flush_if_id=1 (may coincide with START).
//   - FSM: IDLE -> BUSY on START; count loads MULT_CYCLES-1 or DIV_CYCLES-1.
//     BUSY: count decrements every cycle, including MEM_WAIT cycles (unit free-runs);
//     count==0 -> IDLE next edge, so muldiv_busy high exactly N cycles after start pulse.
//     MFHI in the cycle BUSY->IDLE leaves is still stalled; issues the following cycle.
//   - Back-to-back muldiv: second op stalls until IDLE, starts in first IDLE cycle.
//   - ex_wd==0 never causes a load-use stall. Reserved op 11 ignored.
//   - Reset mid-operation abandons the muldiv; unit restarts only on a new START.
// CONFIGURATION
//   HAZARD_CTRL_PERF_EN defined: adds outputs perf_stall_cnt, perf_flush_cnt, perf_muldiv_cnt
//     [CNT_W-1:0]: increment on cycles with stall_pc, flush_if_id, muldiv_start; wrap at 2^CNT_W;
//     zero on reset. Undefined: ports and logic absent, behaviour otherwise identical.
// STRUCTURE
//   Package pipe_ctrl_pkg: FSM state enum (IDLE, BUSY), muldiv_op codes (MD_NONE/MD_MULT/MD_DIV),
//     MIPS func constants MULT 6'h18, MULTU 6'h19, DIV 6'h1a, DIVU 6'h1b, MFHI 6'h10, MFLO 6'h12.
//   Sub-module muldiv_timer: owns FSM + down-counter; inputs start/op; output busy.
//   Top holds priority logic and optional perf counters.
// TESTING
//   1 lw $2 in EX (ex_wd=2), ID add uses rs=2 -> 1 cycle stall_pc/stall_if_id/bubble_id_ex, then none.
//   2 ex_mem_read, ex_wd=0, id_rs=0 -> no stall.
//   3 DIV start, MFHI 2 cycles later (DIV_CYCLES=32) -> muldiv_busy 32 cycles, MFHI stalled until IDLE.
//   4 dmem_busy 3 cycles during MULT -> all stalls high 3 cycles, MULT still finishes at cycle 4.
//   5 load-use + id_branch_taken same cycle, BRANCH_FLUSH=1 -> bubble only, flush on next cycle.
//   6 rst low mid-DIV -> muldiv_busy=0 immediately; PERF counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states, muldiv op codes and MIPS function codes for the pipeline controller.
package pipe_ctrl_pkg;
    typedef enum logic {IDLE, BUSY} md_state_t;
    typedef enum logic [1:0] {MD_NONE = 2'b00, MD_MULT = 2'b01, MD_DIV = 2'b10} md_op_t;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    function automatic logic md_valid(input logic [1:0] op);
        return op == MD_MULT || op == MD_DIV;
    endfunction
endpackage

// File: rtl/muldiv_timer.sv
// muldiv_timer: tracks the in-flight MULT/DIV; busy stays high for exactly the op latency after start.
module muldiv_timer import pipe_ctrl_pkg::*; #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       busy
);
    localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;
    md_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // The count keeps running through memory stalls: the unit is not held by the pipeline.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE && start) begin
            state_nx = BUSY;
            cnt_nx   = op == MD_DIV ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end else if (state == BUSY) begin
            state_nx = cnt == '0 ? IDLE : BUSY;
            cnt_nx   = cnt == '0 ? cnt : cnt - CW'(1);
        end
    end
    assign busy = state == BUSY;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock (memory wait, load-use, HI/LO, muldiv start, branch flush).
// Optional HAZARD_CTRL_PERF_EN adds stall/flush/muldiv-start performance counters.
module hazard_ctrl import pipe_ctrl_pkg::*; #(
    parameter int MULT_CYCLES  = 4,
    parameter int DIV_CYCLES   = 32,
    parameter int BRANCH_FLUSH = 0,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [1:0]       id_muldiv_op,
    input  logic             id_reads_hilo,
    input  logic             id_branch_taken,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wd,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             muldiv_start,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_muldiv_cnt,
`endif
    output logic             muldiv_busy
);
    logic mem_wait, load_use, hilo, md_req;
    assign mem_wait = imem_busy | dmem_busy;
    assign load_use = ex_mem_read && ex_wd != '0 &&
                      ((id_use_rs && id_rs == ex_wd) || (id_use_rt && id_rt == ex_wd));
    assign md_req   = md_valid(id_muldiv_op);
    assign hilo     = muldiv_busy && (md_req || id_reads_hilo);
    // Lower-priority actions are masked by every higher one; flush may still coincide with start.
    always_comb begin
        stall_pc     = mem_wait | load_use | hilo;
        stall_if_id  = mem_wait | load_use | hilo;
        stall_id_ex  = mem_wait;
        bubble_id_ex = !mem_wait && (load_use || hilo);
        muldiv_start = !mem_wait && !load_use && !muldiv_busy && md_req;
        flush_if_id  = !mem_wait && !load_use && !hilo && id_branch_taken && BRANCH_FLUSH != 0;
    end
    muldiv_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_timer (
        .clk(clk), .rst(rst), .start(muldiv_start), .op(id_muldiv_op), .busy(muldiv_busy)
    );
`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_muldiv_cnt <= '0;
        end else begin
            perf_stall_cnt  <= perf_stall_cnt + {{(CNT_W-1){1'b0}}, stall_pc};
            perf_flush_cnt  <= perf_flush_cnt + {{(CNT_W-1){1'b0}}, flush_if_id};
            perf_muldiv_cnt <= perf_muldiv_cnt + {{(CNT_W-1){1'b0}}, muldiv_start};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl priorities and muldiv timing through a scoreboard queue.
module tb_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_wd = '0;
    logic id_use_rs = 0, id_use_rt = 0, id_reads_hilo = 0, id_branch_taken = 0;
    logic ex_mem_read = 0, imem_busy = 0, dmem_busy = 0;
    logic [1:0] id_muldiv_op = '0;
    logic stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, muldiv_start, muldiv_busy;
    logic s0_pc, s0_ifid, s0_idex, b0, flush0, start0, busy0;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] pc_stall, pc_flush, pc_md, p0_stall, p0_flush, p0_md;
`endif
    int n_eval = 0, n_fail = 0;
    logic [6:0] sb[$];
    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .BRANCH_FLUSH(1)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_muldiv_op(id_muldiv_op), .id_reads_hilo(id_reads_hilo),
        .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read), .ex_wd(ex_wd),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .muldiv_start(muldiv_start),
`ifdef HAZARD_CTRL_PERF_EN
        .perf_stall_cnt(pc_stall), .perf_flush_cnt(pc_flush), .perf_muldiv_cnt(pc_md),
`endif
        .muldiv_busy(muldiv_busy));

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .BRANCH_FLUSH(0)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_muldiv_op(id_muldiv_op), .id_reads_hilo(id_reads_hilo),
        .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read), .ex_wd(ex_wd),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .stall_pc(s0_pc),
        .stall_if_id(s0_ifid), .stall_id_ex(s0_idex), .bubble_id_ex(b0),
        .flush_if_id(flush0), .muldiv_start(start0),
`ifdef HAZARD_CTRL_PERF_EN
        .perf_stall_cnt(p0_stall), .perf_flush_cnt(p0_flush), .perf_muldiv_cnt(p0_md),
`endif
        .muldiv_busy(busy0));

    // Expected vector order: {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, muldiv_start, muldiv_busy}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] e, obs;
        sb.push_back(exp);
        @(negedge clk);
        #1;
        e = sb.pop_front();
        obs = {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, muldiv_start, muldiv_busy};
        n_eval++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic e);
        n_eval++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("reset", 7'b0000000);
        rst = 1;
        // load-use on rs, then the bubble has moved on
        ex_mem_read = 1; ex_wd = 5'd2; id_rs = 5'd2; id_use_rs = 1; id_rt = 5'd5;
        chk("load_use_rs", 7'b1101000);
        ex_mem_read = 0; ex_wd = 0;
        chk("load_use_after", 7'b0000000);
        ex_mem_read = 1; ex_wd = 5'd5; id_use_rs = 0; id_use_rt = 1;
        chk("load_use_rt", 7'b1101000);
        id_use_rt = 0;
        chk("rt_not_used", 7'b0000000);
        ex_wd = 0; id_rs = 0; id_use_rs = 1;
        chk("wd_zero", 7'b0000000);
        ex_mem_read = 0; id_use_rs = 0;
        id_muldiv_op = 2'b11;
        chk("reserved_op", 7'b0000000);
        chk("reserved_idle", 7'b0000000);
        // DIV with MFHI two cycles later
        id_muldiv_op = 2'b10;
        chk("div_start", 7'b0000010);
        id_muldiv_op = 0;
        chk("div_k1", 7'b0000001);
        id_reads_hilo = 1;
        for (int k = 2; k <= 32; k++) chk($sformatf("mfhi_stall_k%0d", k), 7'b1101001);
        chk("mfhi_issue", 7'b0000000);
        id_reads_hilo = 0;
        // back-to-back MULT then DIV
        id_muldiv_op = 2'b01;
        chk("mult_start", 7'b0000010);
        id_muldiv_op = 2'b10;
        for (int k = 1; k <= 4; k++) chk($sformatf("b2b_stall_k%0d", k), 7'b1101001);
        chk("b2b_div_start", 7'b0000010);
        id_muldiv_op = 0;
        for (int k = 1; k <= 32; k++) chk($sformatf("div_busy_k%0d", k), 7'b0000001);
        chk("div_done", 7'b0000000);
        // dmem_busy during MULT: the unit still finishes on time
        id_muldiv_op = 2'b01;
        chk("mult2_start", 7'b0000010);
        id_muldiv_op = 0; dmem_busy = 1;
        for (int k = 1; k <= 3; k++) chk($sformatf("memwait_k%0d", k), 7'b1110001);
        dmem_busy = 0;
        chk("mult2_k4", 7'b0000001);
        chk("mult2_done", 7'b0000000);
        // memory wait outranks start and load-use
        imem_busy = 1; id_muldiv_op = 2'b01;
        chk("memwait_vs_start", 7'b1110000);
        ex_mem_read = 1; ex_wd = 5'd7; id_rs = 5'd7; id_use_rs = 1; id_muldiv_op = 0;
        chk("memwait_vs_lu", 7'b1110000);
        imem_busy = 0; ex_mem_read = 0; ex_wd = 0; id_use_rs = 0;
        chk("quiet", 7'b0000000);
        // load-use with taken branch: bubble first, flush next cycle
        ex_mem_read = 1; ex_wd = 5'd3; id_rt = 5'd3; id_use_rt = 1; id_branch_taken = 1;
        chk("lu_branch", 7'b1101000);
        ex_mem_read = 0; ex_wd = 0; id_use_rt = 0;
        chk("branch_flush", 7'b0000100);
        chk1("no_flush_delay_slot", flush0, 1'b0);
        // start and flush together, then reset mid-op
        id_muldiv_op = 2'b10;
        chk("start_and_flush", 7'b0000110);
        id_muldiv_op = 0; id_branch_taken = 0;
        chk("busy_before_rst", 7'b0000001);
        rst = 0;
        chk("rst_mid_div", 7'b0000000);
`ifdef HAZARD_CTRL_PERF_EN
        chk1("perf_stall_zero", pc_stall == 0, 1'b1);
        chk1("perf_flush_zero", pc_flush == 0, 1'b1);
        chk1("perf_md_zero", pc_md == 0, 1'b1);
`endif
        rst = 1;
        chk("no_restart", 7'b0000000);
        chk1("dut0_idle", busy0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
